product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter PROD_W, default 32: width of the signed product arriving from the Booth multiplier datapath.
REQ-002 Parameter ACC_W, default 40: width of the signed accumulator and result, ACC_W >= PROD_W.
REQ-003 Parameter BLOCK_LEN, default 4, range 1..255: number of products summed per output result.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 src_val  input  1  upstream multiplier presents a valid product.
REQ-007 src_ready  output  1  block can accept a product this cycle.
REQ-008 src_data  input  PROD_W  signed product, two's complement.
REQ-009 flush  input  1  request to emit a partial block early.
REQ-010 dest_val  output  1  accumulated result valid.
REQ-011 dest_ready  input  1  downstream accepts the result.
REQ-012 dest_data  output  ACC_W  signed accumulated sum.
REQ-013 dest_cnt  output  8  number of products contained in dest_data.
REQ-014 sat_flag  output  1  result was clamped during this block (see Configuration).

Function
REQ-015 Two states: ACC (collecting) and OUT (holding result); src_ready SHALL be 1 exactly in ACC, dest_val SHALL be 1 exactly in OUT.
REQ-016 Input handshake = src_val & src_ready; output handshake = dest_val & dest_ready.
REQ-017 On each input handshake: acc <= acc + sign-extended src_data to ACC_W; cnt <= cnt + 1.
REQ-018 ACC->OUT when an input handshake occurs with cnt == BLOCK_LEN-1; dest_data = final sum including that product, dest_cnt = BLOCK_LEN, visible the next cycle (1-cycle latency).
REQ-019 ACC->OUT when flush=1 and cnt > 0 with no input handshake; dest_cnt = cnt.
REQ-020 flush=1 coincident with an input handshake: product included, then ACC->OUT with dest_cnt = cnt+1.
REQ-021 flush=1 with cnt == 0 and no handshake: ignored, state stays ACC.
REQ-022 flush in OUT: ignored.
REQ-023 In OUT, dest_data, dest_cnt, sat_flag SHALL remain stable until output handshake.
REQ-024 On output handshake: acc <= 0, cnt <= 0, sat_flag <= 0, OUT->ACC; first new product accepted no earlier than next cycle.
REQ-025 src_val in OUT SHALL not be consumed; src_data not sampled.
REQ-026 Without saturation, overflow wraps modulo 2^ACC_W.

Reset
REQ-027 While rst=0: state ACC, acc 0, cnt 0, dest_data 0, dest_cnt 0, sat_flag 0, dest_val 0, src_ready 0.
REQ-028 src_ready SHALL rise on the first clk edge after rst deasserts; no handshake is accepted during reset.
REQ-029 Reset mid-block or in OUT discards partial sum and pending result immediately.

Configuration
REQ-030 Macro ACC_SAT_EN defined: each addition clamps to signed ACC_W max (2^(ACC_W-1)-1) or min (-2^(ACC_W-1)) on overflow and sets sat_flag, sticky until output handshake.
REQ-031 ACC_SAT_EN undefined: wrap-around per REQ-026, sat_flag tied to 0, no saturation logic synthesised.

Verification
REQ-032 Defaults; products 5, -3, 10, 7 with src_val constant, dest_ready=1 -> dest_val one cycle after 4th handshake, dest_data 19, dest_cnt 4, src_ready low for exactly that cycle.
REQ-033 Products 100, 200 then flush=1 with src_val=0 -> dest_data 300, dest_cnt 2; flush with cnt=0 -> no dest_val.
REQ-034 dest_ready held 0 for 5 cycles in OUT while src_val=1 -> dest_data stable, src_ready 0, no product lost; release -> next block sums from 0.
REQ-035 ACC_SAT_EN, ACC_W=33, BLOCK_LEN=4, products 0x7FFFFFFF x4 -> dest_data 0x0FFFFFFFF, sat_flag 1; without macro -> wrapped value 0x1FFFFFFFC, sat_flag 0.
REQ-036 rst pulsed low after 2 of 4 products, then 4 products of 1 -> dest_data 4, dest_cnt 4; src_ready 0 during reset.

Source files
------------

// File: rtl/product_accumulator.sv
// Purpose: sums blocks of signed Booth products into ACC_W-bit results; optional ACC_SAT_EN clamps each addition.
// Latency: a result is visible one cycle after the handshake that completes its block (or after a flush).
// Backpressure: src_ready drops while a result is held; dest_data/dest_cnt/sat_flag stay stable until dest_ready.
module product_accumulator #(
    parameter int PROD_W    = 32,
    parameter int ACC_W     = 40,
    parameter int BLOCK_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_val,
    output logic              src_ready,
    input  logic [PROD_W-1:0] src_data,
    input  logic              flush,
    output logic              dest_val,
    input  logic              dest_ready,
    output logic [ACC_W-1:0]  dest_data,
    output logic [7:0]        dest_cnt,
    output logic              sat_flag
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(BLOCK_LEN - 1);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [7:0]         cnt;
    logic [7:0]         cnt_inc;
    logic               in_hs;
    logic               out_hs;
    logic signed [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0]   sum_wrap;
    logic [ACC_W-1:0]   acc_add;

    assign in_hs    = src_val & src_ready;
    assign out_hs   = dest_val & dest_ready;
    assign cnt_inc  = cnt + 8'd1;
    assign prod_ext = ACC_W'($signed(src_data));
    assign sum_wrap = acc + prod_ext;

`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic ovf;
    logic sat_q;

    // Overflow only possible when both operands share a sign and the sum's sign differs.
    assign ovf     = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_wrap[ACC_W-1] != acc[ACC_W-1]);
    assign acc_add = ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_wrap;

    // Sticky clamp indicator for the current block, cleared when the result is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else if (out_hs) begin
            sat_q <= 1'b0;
        end else if (in_hs && ovf) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    assign acc_add  = sum_wrap;
    assign sat_flag = 1'b0;
`endif

    // Collect/hold state machine; handshake outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            dest_data <= '0;
            dest_cnt  <= '0;
            src_ready <= 1'b0;
            dest_val  <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_hs) begin
                        acc <= acc_add;
                        cnt <= cnt_inc;
                        if ((cnt == LAST_IDX) || flush) begin
                            state     <= ST_OUT;
                            dest_data <= acc_add;
                            dest_cnt  <= cnt_inc;
                            src_ready <= 1'b0;
                            dest_val  <= 1'b1;
                        end else begin
                            src_ready <= 1'b1;
                        end
                    end else if (flush && (cnt != 8'd0)) begin
                        // Early emit of a partial block; an empty block is never emitted.
                        state     <= ST_OUT;
                        dest_data <= acc;
                        dest_cnt  <= cnt;
                        src_ready <= 1'b0;
                        dest_val  <= 1'b1;
                    end else begin
                        // Also raises src_ready on the first edge after reset.
                        src_ready <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_hs) begin
                        state     <= ST_ACC;
                        acc       <= '0;
                        cnt       <= '0;
                        src_ready <= 1'b1;
                        dest_val  <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_ACC;
                    src_ready <= 1'b0;
                    dest_val  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int PW = 32;
    localparam int AW = 40;
    localparam int BL = 4;
`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          src_val, flush, dest_ready;
    logic [PW-1:0] src_data;
    logic          src_ready, dest_val, sat_flag;
    logic [AW-1:0] dest_data;
    logic [7:0]    dest_cnt;

    logic          src_val2, flush2, dest_ready2;
    logic [31:0]   src_data2;
    logic          src_ready2, dest_val2, sat_flag2;
    logic [32:0]   dest_data2;
    logic [7:0]    dest_cnt2;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(PW), .ACC_W(AW), .BLOCK_LEN(BL)) dut (
        .clk(clk), .rst(rst), .src_val(src_val), .src_ready(src_ready),
        .src_data(src_data), .flush(flush), .dest_val(dest_val),
        .dest_ready(dest_ready), .dest_data(dest_data), .dest_cnt(dest_cnt),
        .sat_flag(sat_flag)
    );

    product_accumulator #(.PROD_W(32), .ACC_W(33), .BLOCK_LEN(4)) dut2 (
        .clk(clk), .rst(rst), .src_val(src_val2), .src_ready(src_ready2),
        .src_data(src_data2), .flush(flush2), .dest_val(dest_val2),
        .dest_ready(dest_ready2), .dest_data(dest_data2), .dest_cnt(dest_cnt2),
        .sat_flag(sat_flag2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: block contents as plain integers.
    bit     m_hold;
    bit     m_rdy;
    longint m_sum;
    int     m_cnt;
    bit     m_sat;
    longint m_out;
    int     m_out_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint madd(input longint s, input longint p);
        longint r, m, mx, mn;
        m  = longint'(1) <<< AW;
        mx = (longint'(1) <<< (AW - 1)) - 1;
        mn = -mx - 1;
        r  = s + p;
        if (SAT) begin
            if (r > mx) begin
                r = mx; m_sat = 1'b1;
            end else if (r < mn) begin
                r = mn; m_sat = 1'b1;
            end
        end else begin
            r = ((r % m) + m) % m;
            if (r > mx) r = r - m;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_hold = 1'b0; m_rdy = 1'b0; m_sum = 0; m_cnt = 0; m_sat = 1'b0;
        m_out = 0; m_out_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [AW-1:0] e;
        e = AW'(m_out);
        chk({tag, ".src_ready"}, 64'(src_ready), 64'(m_rdy));
        chk({tag, ".dest_val"}, 64'(dest_val), 64'(m_hold));
        if (m_hold) begin
            chk({tag, ".dest_data"}, 64'(dest_data), 64'(e));
            chk({tag, ".dest_cnt"}, 64'(dest_cnt), 64'(m_out_cnt));
            chk({tag, ".sat_flag"}, 64'(sat_flag), 64'(m_sat));
        end
    endtask

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic cyc(input string tag, input bit v, input int d, input bit f, input bit r);
        src_val = v; src_data = d; flush = f; dest_ready = r;
        if (m_hold) begin
            if (r) begin
                m_hold = 1'b0; m_sum = 0; m_cnt = 0; m_sat = 1'b0;
            end
        end else if (m_rdy && v) begin
            m_sum = madd(m_sum, longint'(d));
            m_cnt++;
            if (m_cnt == BL || f) begin
                m_hold = 1'b1; m_out = m_sum; m_out_cnt = m_cnt;
            end
        end else if (f && m_cnt > 0) begin
            m_hold = 1'b1; m_out = m_sum; m_out_cnt = m_cnt;
        end
        m_rdy = !m_hold;
        @(posedge clk); #1;
        check_outputs(tag);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".src_ready"}, 64'(src_ready), 64'(0));
        chk({tag, ".dest_val"}, 64'(dest_val), 64'(0));
        chk({tag, ".dest_data"}, 64'(dest_data), 64'(0));
        chk({tag, ".dest_cnt"}, 64'(dest_cnt), 64'(0));
        chk({tag, ".sat_flag"}, 64'(sat_flag), 64'(0));
        chk({tag, ".src_ready2"}, 64'(src_ready2), 64'(0));
    endtask

    initial begin
        rst = 1'b0; src_val = 1'b0; flush = 1'b0; dest_ready = 1'b0; src_data = '0;
        src_val2 = 1'b0; flush2 = 1'b0; dest_ready2 = 1'b0; src_data2 = '0;
        model_reset();

        // Reset state, with a product offered during reset.
        #1;
        check_reset_state("rst_init");
        src_val = 1'b1; src_data = 32'd123;
        @(posedge clk); #1;
        check_reset_state("rst_hold");
        src_val = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_release.src_ready", 64'(src_ready), 64'(0));
        @(negedge clk);
        cyc("first_edge", 1'b0, 0, 1'b0, 1'b1);
        chk("first_edge.ready_up", 64'(src_ready), 64'(1));

        // Full block 5,-3,10,7 with src_val held high.
        cyc("blk_a0", 1'b1, 5, 1'b0, 1'b1);
        cyc("blk_a1", 1'b1, -3, 1'b0, 1'b1);
        cyc("blk_a2", 1'b1, 10, 1'b0, 1'b1);
        cyc("blk_a3", 1'b1, 7, 1'b0, 1'b1);
        chk("blk_a.dest_data", 64'(dest_data), 64'(19));
        chk("blk_a.dest_cnt", 64'(dest_cnt), 64'(4));
        chk("blk_a.src_ready_low", 64'(src_ready), 64'(0));
        cyc("blk_a_take", 1'b1, 99, 1'b0, 1'b1);
        chk("blk_a.src_ready_back", 64'(src_ready), 64'(1));
        cyc("blk_a_idle", 1'b0, 0, 1'b0, 1'b1);

        // Flush of a partial block, then a flush with nothing collected.
        cyc("fl_0", 1'b1, 100, 1'b0, 1'b0);
        cyc("fl_1", 1'b1, 200, 1'b0, 1'b0);
        cyc("fl_2", 1'b0, 0, 1'b1, 1'b0);
        chk("flush.dest_data", 64'(dest_data), 64'(300));
        chk("flush.dest_cnt", 64'(dest_cnt), 64'(2));
        cyc("fl_in_out", 1'b0, 0, 1'b1, 1'b1);
        cyc("fl_empty", 1'b0, 0, 1'b1, 1'b1);
        chk("flush_empty.dest_val", 64'(dest_val), 64'(0));

        // Flush coincident with a product.
        cyc("flc_0", 1'b1, -40, 1'b0, 1'b1);
        cyc("flc_1", 1'b1, 15, 1'b1, 1'b0);
        chk("flush_hs.dest_cnt", 64'(dest_cnt), 64'(2));
        cyc("flc_take", 1'b0, 0, 1'b0, 1'b1);

        // Downstream stall for 5 cycles with products offered.
        cyc("st_0", 1'b1, 1, 1'b0, 1'b0);
        cyc("st_1", 1'b1, 2, 1'b0, 1'b0);
        cyc("st_2", 1'b1, 3, 1'b0, 1'b0);
        cyc("st_3", 1'b1, 4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc("stall", 1'b1, 777, 1'b0, 1'b0);
            chk("stall.dest_data", 64'(dest_data), 64'(10));
            chk("stall.src_ready", 64'(src_ready), 64'(0));
        end
        cyc("st_take", 1'b1, 11, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc("st_next", 1'b1, 1, 1'b0, 1'b0);
        chk("st_next.dest_data", 64'(dest_data), 64'(4));
        cyc("st_next_take", 1'b0, 0, 1'b0, 1'b1);

        // Reset mid-block discards the partial sum.
        cyc("mr_0", 1'b1, 50, 1'b0, 1'b1);
        cyc("mr_1", 1'b1, 60, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check_reset_state("rst_mid");
        model_reset();
        src_val = 1'b1; src_data = 32'd9;
        @(posedge clk); #1;
        chk("rst_mid.src_ready_hold", 64'(src_ready), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        cyc("mr_first", 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc("mr_ones", 1'b1, 1, 1'b0, 1'b0);
        chk("rst_mid.dest_data", 64'(dest_data), 64'(4));
        chk("rst_mid.dest_cnt", 64'(dest_cnt), 64'(4));
        cyc("mr_take", 1'b0, 0, 1'b0, 1'b1);

        // Randomised traffic including extreme operands.
        for (int i = 0; i < 400; i++) begin
            int d;
            case ($urandom_range(0, 5))
                0: d = 32'h7FFF_FFFF;
                1: d = 32'h8000_0000;
                default: d = int'($urandom);
            endcase
            cyc("rand", ($urandom_range(0, 3) != 0), d, ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2) != 0));
        end

        // Narrow accumulator: four maximum positive products.
        src_val2 = 1'b1; src_data2 = 32'h7FFF_FFFF;
        chk("narrow.src_ready", 64'(src_ready2), 64'(1));
        repeat (4) begin
            @(posedge clk); #1;
        end
        src_val2 = 1'b0;
        chk("narrow.dest_val", 64'(dest_val2), 64'(1));
        chk("narrow.dest_cnt", 64'(dest_cnt2), 64'(4));
        if (SAT) begin
            chk("narrow.dest_data", 64'(dest_data2), 64'h0_FFFF_FFFF);
            chk("narrow.sat_flag", 64'(sat_flag2), 64'(1));
        end else begin
            chk("narrow.dest_data", 64'(dest_data2), 64'h1_FFFF_FFFC);
            chk("narrow.sat_flag", 64'(sat_flag2), 64'(0));
        end
        dest_ready2 = 1'b1;
        @(posedge clk); #1;
        dest_ready2 = 1'b0;
        chk("narrow.released", 64'(dest_val2), 64'(0));
        chk("narrow.sat_cleared", 64'(sat_flag2), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
